// File: rtl/garbage_queue_ctrl_pkg.sv
// rtl/garbage_queue_ctrl_pkg.sv - shared constants, state type and helpers for the garbage queue
// Contents: MAX_PENDING, MAX_LOAD_PER_LOCK, PLAYFIELD_COLS, garbage_state_t,
//           attack_rows() lines-to-attack table, hole_of() LFSR-to-column map.
package GamePkg;

    localparam int MAX_PENDING       = 20;
    localparam int MAX_LOAD_PER_LOCK = 8;
    localparam int PLAYFIELD_COLS    = 10;

    typedef enum logic {
        IDLE,
        LOAD
    } garbage_state_t;

    // Attack generated by a lock clearing 'lines' rows; out-of-range counts attack nothing.
    function automatic logic [2:0] attack_rows(input logic [2:0] lines);
        case (lines)
            3'd2:    attack_rows = 3'd1;
            3'd3:    attack_rows = 3'd2;
            3'd4:    attack_rows = 3'd4;
            default: attack_rows = 3'd0;
        endcase
    endfunction

    // Folds the low nibble onto a playfield column (10..15 wrap to 0..5).
    function automatic logic [3:0] hole_of(input logic [15:0] x);
        hole_of = (x[3:0] >= 4'(PLAYFIELD_COLS)) ? (x[3:0] - 4'(PLAYFIELD_COLS)) : x[3:0];
    endfunction

endpackage

// File: rtl/garbage_hole_lfsr.sv
// rtl/garbage_hole_lfsr.sv - 16-bit Fibonacci LFSR choosing the hole column of a garbage batch
// Ports: clk, rst (sync, active-high), advance (step once), seed (reset value, non-zero),
//        hole_col[3:0] (column 0..9 derived from the current LFSR state).
module garbage_hole_lfsr
    import GamePkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [3:0]  hole_col
);

    logic [15:0] lfsr;
    logic        feedback;

    // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign hole_col = hole_of(lfsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/garbage_queue_ctrl.sv
// rtl/garbage_queue_ctrl.sv - pending-garbage accumulator, attack cancel/forward and row loader
// Ports: clk, rst (sync, active-high); recv_valid/recv_cnt incoming attack;
//        piece_locked/lock_lines lock event; load_ready/load_valid/load_hole_col row handshake;
//        send_valid/send_cnt forwarded attack; pending_garbage count; load_busy (in LOAD).
module garbage_queue_ctrl
    import GamePkg::*;
#(
    parameter int          MAX_PENDING       = GamePkg::MAX_PENDING,
    parameter int          MAX_LOAD_PER_LOCK = GamePkg::MAX_LOAD_PER_LOCK,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       recv_valid,
    input  logic [2:0] recv_cnt,
    input  logic       piece_locked,
    input  logic [2:0] lock_lines,
    input  logic       load_ready,
    output logic       load_valid,
    output logic [3:0] load_hole_col,
    output logic       send_valid,
    output logic [2:0] send_cnt,
    output logic [4:0] pending_garbage,
    output logic       load_busy
);

    localparam logic [5:0] MAX_P6 = 6'(MAX_PENDING);
    localparam logic [5:0] MAX_L6 = 6'(MAX_LOAD_PER_LOCK);

    garbage_state_t state;
    logic [3:0]     batch;
    logic [5:0]     sum;
    logic [5:0]     p1;
    logic [5:0]     atk;
    logic           transfer;
    logic           start_load;
    logic [3:0]     hole_col;

    // 6-bit intermediates so neither the add nor the cancel subtraction can wrap.
    assign sum        = {1'b0, pending_garbage} + (recv_valid ? {3'b000, recv_cnt} : 6'd0);
    assign p1         = (sum > MAX_P6) ? MAX_P6 : sum;
    assign atk        = {3'b000, attack_rows(lock_lines)};
    assign transfer   = load_valid && load_ready;
    assign start_load = (state == IDLE) && piece_locked && (lock_lines == 3'd0) && (p1 != 6'd0);

    garbage_hole_lfsr u_hole_lfsr (
        .clk      (clk),
        .rst      (rst),
        .advance  (start_load),
        .seed     (LFSR_SEED),
        .hole_col (hole_col)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            batch           <= 4'd0;
            pending_garbage <= 5'd0;
            load_valid      <= 1'b0;
            load_hole_col   <= 4'd0;
            load_busy       <= 1'b0;
            send_valid      <= 1'b0;
            send_cnt        <= 3'd0;
        end else begin
            send_valid <= 1'b0;
            case (state)
                IDLE: begin
                    pending_garbage <= p1[4:0];
                    if (piece_locked && (atk != 6'd0)) begin
                        if (atk <= p1) begin
                            pending_garbage <= 5'(p1 - atk);
                        end else begin
                            pending_garbage <= 5'd0;
                            send_valid      <= 1'b1;
                            send_cnt        <= 3'(atk - p1);
                        end
                    end else if (start_load) begin
                        state         <= LOAD;
                        batch         <= (p1 > MAX_L6) ? 4'(MAX_L6) : 4'(p1);
                        load_valid    <= 1'b1;
                        load_busy     <= 1'b1;
                        load_hole_col <= hole_col;
                    end
                end
                LOAD: begin
                    // pending >= batch >= 1 throughout LOAD, so the decrement cannot underflow.
                    // A lock here is a protocol error and is deliberately ignored.
                    if (transfer) begin
                        pending_garbage <= 5'(p1 - 6'd1);
                        batch           <= batch - 4'd1;
                        if (batch == 4'd1) begin
                            state      <= IDLE;
                            load_valid <= 1'b0;
                            load_busy  <= 1'b0;
                        end
                    end else begin
                        pending_garbage <= p1[4:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
